// File: rtl/lane_tick_scheduler.sv
// Shared-prescaler lane move scheduler: per-lane period countdowns raise pending
// requests, and a round-robin arbiter grants at most one registered move pulse per clock.
module lane_tick_scheduler #(
  parameter int LANES    = 4,
  parameter int PRESCALE = 4,
  parameter int PW       = 8,
  localparam int LW      = $clog2(LANES),
  localparam int PCW     = $clog2(PRESCALE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pause,
  input  logic             cfg_we,
  input  logic [LW-1:0]    cfg_lane,
  input  logic [PW-1:0]    cfg_period,
  input  logic [2:0]       level,
  input  logic             clr_missed,
  output logic [LANES-1:0] move,
  output logic             move_valid,
  output logic [LW-1:0]    move_lane,
  output logic [LANES-1:0] missed
);

  logic [PCW-1:0]   pcnt;
  logic [PW-1:0]    period [LANES];
  logic [PW-1:0]    lcnt   [LANES];
  logic [LANES-1:0] pending;
  logic [LW-1:0]    rr;

  logic             base_tick;
  logic             tick_en;
  logic [LANES-1:0] wr_hit;
  logic [LANES-1:0] expire;
  logic [LANES-1:0] eligible;
  logic [LANES-1:0] grant;
  logic [LANES-1:0] miss_set;
  logic             gnt_any;
  logic [LW-1:0]    gnt_idx;

  // Only meaningful for a non-zero period; a shift to zero clamps to one tick.
  function automatic logic [PW-1:0] eff_of(input logic [PW-1:0] p, input logic [2:0] lv);
    logic [PW-1:0] s;
    s = p >> lv;
    return (s == '0) ? PW'(1) : s;
  endfunction

  assign base_tick = (pcnt == PCW'(PRESCALE - 1));
  assign tick_en   = base_tick && !pause;

  always_comb begin
    wr_hit = '0;
    expire = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_hit[i] = cfg_we && (cfg_lane == LW'(i));
      expire[i] = tick_en && (period[i] != '0) && (lcnt[i] == '0);
    end
  end

  // A lane being rewritten this edge is removed from arbitration so the write wins.
  always_comb begin
    logic [LW-1:0] k;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    k        = '0;
    eligible = pending & ~wr_hit;
    for (int j = 0; j < LANES; j++) begin
      k = LW'((int'(rr) + j) % LANES);
      if (!gnt_any && eligible[k]) begin
        gnt_any = 1'b1;
        gnt_idx = k;
      end
    end
    if (pause) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
    grant    = gnt_any ? (LANES'(1) << gnt_idx) : '0;
    miss_set = expire & pending & ~grant & ~wr_hit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt       <= '0;
      pending    <= '0;
      rr         <= '0;
      missed     <= '0;
      move       <= '0;
      move_valid <= 1'b0;
      move_lane  <= '0;
      for (int i = 0; i < LANES; i++) begin
        period[i] <= '0;
        lcnt[i]   <= '0;
      end
    end else begin
      if (!pause) pcnt <= base_tick ? '0 : pcnt + 1'b1;
      if (gnt_any) rr <= (gnt_idx == LW'(LANES - 1)) ? '0 : gnt_idx + 1'b1;
      move       <= grant;
      move_valid <= gnt_any;
      move_lane  <= gnt_idx;
      missed     <= (clr_missed ? '0 : missed) | miss_set;
      for (int i = 0; i < LANES; i++) begin
        if (wr_hit[i]) begin
          period[i]  <= cfg_period;
          lcnt[i]    <= (cfg_period == '0) ? '0 : eff_of(cfg_period, level) - 1'b1;
          pending[i] <= 1'b0;
        end else if (expire[i]) begin
          // A grant on the same edge is overtaken by the fresh expiry.
          pending[i] <= 1'b1;
          lcnt[i]    <= eff_of(period[i], level) - 1'b1;
        end else begin
          if (tick_en && (period[i] != '0)) lcnt[i] <= lcnt[i] - 1'b1;
          if (grant[i]) pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule
